seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Iterative signed 32-bit divider for the multicycle CPU, implementing MIPS DIV.
//  It sits upstream of the HI/LO input muxes and the HI/LO registers.
//  It takes operands from the A/B registers, runs one quotient bit per cycle,
//  and hands remainder (HI) and quotient (LO) to the HI/LO path.
//  It reports completion and divide-by-zero to the control unit.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; counter is $clog2(WIDTH)+1 bits
// PORTS
//  clk       in   1      system clock, rising edge
//  reset     in   1      asynchronous, active-low reset
//  start     in   1      request; sampled only in IDLE
//  dividend  in   WIDTH  signed dividend (A register), sampled with start
//  divisor   in   WIDTH  signed divisor (B register), sampled with start
//  hi        out  WIDTH  remainder, registered
//  lo        out  WIDTH  quotient, registered
//  busy      out  1      high in every state except IDLE
//  done      out  1      one-cycle pulse: result (or zero fault) ready
//  div_zero  out  1      one-cycle pulse with done when divisor==0
// BEHAVIOUR
//  Reset (reset==0, async):
//   - state=IDLE; hi, lo and all internal registers are 0.
//   - busy, done and div_zero are 0.
//   - Applies immediately, including mid-division; the operation is discarded.
//  States: IDLE -> LOAD -> RUN -> FIX -> DONE -> IDLE.
//  IDLE: start==1 at edge E0 latches the operands -> LOAD.
//   - Otherwise stay in IDLE; outputs hold their last values.
//  LOAD (edge E1):
//   - If divisor==0 -> DONE with zero flag set; hi/lo keep their prior values.
//   - Else latch |dividend| and |divisor|, remember both signs, clear the
//     partial remainder, set count=WIDTH -> RUN.
//  RUN: restoring division, one step per edge for WIDTH edges.
//   - rem = {rem[W-2:0], q[W-1]}; q <<= 1.
//   - If rem >= dvsr (unsigned, WIDTH+1-bit compare): rem -= dvsr, q[0]=1.
//   - count decrements each step; after the last step -> FIX.
//  FIX: write lo and hi (registered), then -> DONE.
//   - lo = q, negated if sign(dividend)^sign(divisor).
//   - hi = rem, negated if sign(dividend).
//   - Quotient truncates toward zero; the remainder takes the dividend's sign.
//  DONE: done=1 for exactly one cycle; div_zero=1 only on the zero path
//   -> IDLE.
//  Latency:
//   - Normal: done high in the cycle after edge E0+WIDTH+3 (35 cycles at 32).
//   - Zero divisor: done high in the cycle after edge E0+2.
//  Width rules: abs(0x80000000) is taken as the unsigned value 2^31; no overflow.
//   - 0x80000000 / -1 -> lo=0x80000000 (two's-complement wrap), hi=0; no fault flag.
//  start while busy: ignored, no queuing; operands are not resampled.
//  start held high through DONE: a new operation begins at the first IDLE edge.
//  The control unit asserts WriteHILO with HILOCtrl=div on the done cycle.
//  hi/lo stay stable from FIX until the next FIX or reset.
// TESTING
//  1. 100 / 7 -> lo=14, hi=2; done pulses once, exactly 35 cycles after start.
//  2. -100 / 7 -> lo=-14 (0xFFFFFFF2), hi=-2.
//     100 / -7 -> lo=-14, hi=2.
//     -100 / -7 -> lo=14, hi=-2.
//  3. Divisor 0 with dividend 5 -> done and div_zero pulse together 2 cycles
//     after start; hi/lo unchanged from the previous result; busy drops.
//  4. 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
//     0x80000000 / 1 -> lo=0x80000000, hi=0.
//  5. Start 1000/3, pulse start again with 8/2 at cycle 10 -> second start
//     ignored; result lo=333, hi=1; done pulses once.
//  6. Drive reset low at cycle 20 of 1000/3 -> hi=lo=0, busy=0 immediately.
//     After release, start 9/4 -> lo=2, hi=1 in 35 cycles.

Source files
------------

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//
// Iterative signed divider for the multicycle CPU (MIPS DIV). Operands come
// from the A/B registers; the remainder goes to HI and the quotient to LO.
// The divider uses a restoring algorithm on magnitudes and produces one
// quotient bit per clock. Signs are applied afterwards.
//
// Ports
//   clk       in   1      system clock, rising edge
//   reset     in   1      asynchronous, active-low reset
//   start     in   1      request; sampled only while idle
//   dividend  in   WIDTH  signed dividend, captured with start
//   divisor   in   WIDTH  signed divisor, captured with start
//   hi        out  WIDTH  remainder (sign of dividend), registered
//   lo        out  WIDTH  quotient (truncated toward zero), registered
//   busy      out  1      high whenever the FSM is not idle
//   done      out  1      one-cycle pulse: result or zero fault ready
//   div_zero  out  1      one-cycle pulse, coincident with done, on divisor==0
//
// Timing, with start seen at edge E0:
//   normal path: done is high in the cycle after edge E0+WIDTH+3
//   zero divisor: done is high in the cycle after edge E0+2
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StLoad = 3'd1;
    localparam logic [2:0] StRun  = 3'd2;
    localparam logic [2:0] StFix  = 3'd3;
    localparam logic [2:0] StDone = 3'd4;

    // State and datapath registers
    logic [2:0]       stateQ, stateD;
    logic [WIDTH-1:0] opAQ, opAD;       // captured dividend
    logic [WIDTH-1:0] opBQ, opBD;       // captured divisor
    logic [WIDTH-1:0] quoQ, quoD;       // |dividend| shifting out, quotient shifting in
    logic [WIDTH-1:0] remQ, remD;       // partial remainder
    logic [WIDTH-1:0] dvsrQ, dvsrD;     // |divisor|
    logic [CntW-1:0]  cntQ, cntD;
    logic             negQuoQ, negQuoD;
    logic             negRemQ, negRemD;
    logic             zeroQ, zeroD;
    logic [WIDTH-1:0] hiQ, hiD;
    logic [WIDTH-1:0] loQ, loD;
    logic             doneQ, doneD;
    logic             divZeroQ, divZeroD;

    // One restoring step: shift the next dividend bit into the remainder and
    // try to subtract. The extra top bit keeps the compare exact when the
    // divisor magnitude is 2^(WIDTH-1).
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;
    logic             fits;

    assign trial = {remQ, quoQ[WIDTH-1]};
    assign fits  = (trial >= {1'b0, dvsrQ});
    // Only used when fits, so the result always lands below dvsrQ.
    assign diff  = trial[WIDTH-1:0] - dvsrQ;

    always_comb begin
        stateD   = stateQ;
        opAD     = opAQ;
        opBD     = opBQ;
        quoD     = quoQ;
        remD     = remQ;
        dvsrD    = dvsrQ;
        cntD     = cntQ;
        negQuoD  = negQuoQ;
        negRemD  = negRemQ;
        zeroD    = zeroQ;
        hiD      = hiQ;
        loD      = loQ;
        doneD    = 1'b0;
        divZeroD = 1'b0;

        case (stateQ)
            StIdle: begin
                if (start) begin
                    opAD   = dividend;
                    opBD   = divisor;
                    stateD = StLoad;
                end
            end

            StLoad: begin
                if (opBQ == '0) begin
                    // Fault path leaves hi/lo untouched.
                    zeroD  = 1'b1;
                    stateD = StDone;
                end else begin
                    // Negating the most negative value wraps to itself, which
                    // read as unsigned is exactly its magnitude.
                    quoD    = opAQ[WIDTH-1] ? -opAQ : opAQ;
                    dvsrD   = opBQ[WIDTH-1] ? -opBQ : opBQ;
                    negQuoD = opAQ[WIDTH-1] ^ opBQ[WIDTH-1];
                    negRemD = opAQ[WIDTH-1];
                    remD    = '0;
                    cntD    = CntW'(WIDTH);
                    zeroD   = 1'b0;
                    stateD  = StRun;
                end
            end

            StRun: begin
                if (fits) begin
                    remD = diff;
                    quoD = {quoQ[WIDTH-2:0], 1'b1};
                end else begin
                    remD = trial[WIDTH-1:0];
                    quoD = {quoQ[WIDTH-2:0], 1'b0};
                end
                cntD = cntQ - CntW'(1);
                if (cntQ == CntW'(1)) begin
                    stateD = StFix;
                end
            end

            StFix: begin
                loD    = negQuoQ ? -quoQ : quoQ;
                hiD    = negRemQ ? -remQ : remQ;
                stateD = StDone;
            end

            StDone: begin
                // done/div_zero are registered here so they appear one cycle
                // later, together with the return to idle.
                doneD    = 1'b1;
                divZeroD = zeroQ;
                stateD   = StIdle;
            end

            default: begin
                stateD = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ   <= StIdle;
            opAQ     <= '0;
            opBQ     <= '0;
            quoQ     <= '0;
            remQ     <= '0;
            dvsrQ    <= '0;
            cntQ     <= '0;
            negQuoQ  <= 1'b0;
            negRemQ  <= 1'b0;
            zeroQ    <= 1'b0;
            hiQ      <= '0;
            loQ      <= '0;
            doneQ    <= 1'b0;
            divZeroQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            opAQ     <= opAD;
            opBQ     <= opBD;
            quoQ     <= quoD;
            remQ     <= remD;
            dvsrQ    <= dvsrD;
            cntQ     <= cntD;
            negQuoQ  <= negQuoD;
            negRemQ  <= negRemD;
            zeroQ    <= zeroD;
            hiQ      <= hiD;
            loQ      <= loD;
            doneQ    <= doneD;
            divZeroQ <= divZeroD;
        end
    end

    assign hi       = hiQ;
    assign lo       = loQ;
    assign busy     = (stateQ != StIdle);
    assign done     = doneQ;
    assign div_zero = divZeroQ;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int errors = 0;
    int checks = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eLo;
        logic [31:0] eHi;
        logic        eZ;
        int          eLat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic checkInt(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: 64-bit signed arithmetic gives truncating division with the
    // remainder following the dividend, and the INT_MIN/-1 case wraps when
    // the quotient is cut back to 32 bits.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pHi, input logic [31:0] pLo,
                         output logic [31:0] eHi, output logic [31:0] eLo,
                         output logic eZ, output int eLat);
        longint sa, sb, q, r;
        if (b == 32'd0) begin
            eHi  = pHi;
            eLo  = pLo;
            eZ   = 1'b1;
            eLat = 2;
        end else begin
            sa   = longint'($signed(a));
            sb   = longint'($signed(b));
            q    = sa / sb;
            r    = sa % sb;
            eLo  = q[31:0];
            eHi  = r[31:0];
            eZ   = 1'b0;
            eLat = 35;
        end
    endtask

    // Issue one operation and wait (bounded) for done. lat counts edges after
    // the start-sampling edge up to the one after which done is seen.
    task automatic runOp(input logic [31:0] a, input logic [31:0] b, output int lat,
                         output logic [31:0] gotHi, output logic [31:0] gotLo,
                         output logic gotZ);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy after start", {31'd0, busy}, 32'd1);
        lat   = -1;
        gotHi = 'x;
        gotLo = 'x;
        gotZ  = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat   = i;
                gotHi = hi;
                gotLo = lo;
                gotZ  = div_zero;
                break;
            end
        end
        @(posedge clk);
        #1;
        check("done single pulse", {31'd0, done}, 32'd0);
        check("busy dropped", {31'd0, busy}, 32'd0);
    endtask

    vec_t        vecs [10];
    int          lat;
    logic [31:0] gHi, gLo;
    logic        gZ;
    logic [31:0] prevHi, prevLo;
    logic [31:0] eHi, eLo;
    logic        eZ;
    int          eLat;
    int          pulses;

    initial begin
        // Directed table; expected values are hand-derived.
        vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 35};
        vecs[1] = '{32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 35};
        vecs[2] = '{32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, 35};
        vecs[3] = '{32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0, 35};
        vecs[4] = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 35};
        vecs[5] = '{32'h80000000,   32'd1,          32'h80000000,   32'd0,          1'b0, 35};
        vecs[6] = '{32'hFFFFFFFF,   32'h80000000,   32'd0,          32'hFFFFFFFF,   1'b0, 35};
        vecs[7] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 35};
        vecs[8] = '{32'd7,          32'd100,        32'd0,          32'd7,          1'b0, 35};
        // Zero divisor: hi/lo keep the 7/100 result.
        vecs[9] = '{32'd5,          32'd0,          32'd0,          32'd7,          1'b1, 2};

        reset    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset busy/done/zero", {29'd0, busy, done, div_zero}, 32'd0);
        #12;
        reset = 1'b1;

        for (int k = 0; k < 10; k++) begin
            runOp(vecs[k].a, vecs[k].b, lat, gHi, gLo, gZ);
            checkInt($sformatf("vec%0d latency", k), lat, vecs[k].eLat);
            check($sformatf("vec%0d lo", k), gLo, vecs[k].eLo);
            check($sformatf("vec%0d hi", k), gHi, vecs[k].eHi);
            check($sformatf("vec%0d div_zero", k), {31'd0, gZ}, {31'd0, vecs[k].eZ});
        end
        prevHi = vecs[9].eHi;
        prevLo = vecs[9].eLo;

        // Randomized operations against the arithmetic model.
        for (int k = 0; k < 24; k++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = $urandom_range(0, 1) ? 32'($urandom_range(1, 15))
                                            : -32'($urandom_range(1, 15));
                2: a = 32'h80000000;
                3: b = 32'hFFFFFFFF;
                default: ;
            endcase
            model(a, b, prevHi, prevLo, eHi, eLo, eZ, eLat);
            runOp(a, b, lat, gHi, gLo, gZ);
            checkInt($sformatf("rand%0d latency", k), lat, eLat);
            check($sformatf("rand%0d lo (%h/%h)", k, a, b), gLo, eLo);
            check($sformatf("rand%0d hi (%h/%h)", k, a, b), gHi, eHi);
            check($sformatf("rand%0d div_zero", k), {31'd0, gZ}, {31'd0, eZ});
            prevHi = eHi;
            prevLo = eLo;
        end

        // Second start while busy is ignored.
        @(negedge clk);
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        lat    = -1;
        pulses = 0;
        gHi    = 'x;
        gLo    = 'x;
        for (int i = 1; i <= 60; i++) begin
            if (i == 10) begin
                @(negedge clk);
                dividend = 32'd8;
                divisor  = 32'd2;
                start    = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                pulses++;
                if (lat < 0) begin
                    lat = i;
                    gHi = hi;
                    gLo = lo;
                end
            end
        end
        checkInt("busy-start latency", lat, 35);
        checkInt("busy-start done pulses", pulses, 1);
        check("busy-start lo", gLo, 32'd333);
        check("busy-start hi", gHi, 32'd1);

        // Asynchronous reset mid-division (hi/lo hold 333/1 beforehand).
        @(negedge clk);
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("mid reset hi", hi, 32'd0);
        check("mid reset lo", lo, 32'd0);
        check("mid reset busy/done", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        runOp(32'd9, 32'd4, lat, gHi, gLo, gZ);
        checkInt("post-reset latency", lat, 35);
        check("post-reset lo", gLo, 32'd2);
        check("post-reset hi", gHi, 32'd1);
        check("post-reset div_zero", {31'd0, gZ}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
